// File: rtl/binary_to_bcd_seq_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the sequential binary-to-BCD
//               converter: digit width, FSM state encoding and an
//               elaboration-time power-of-ten helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 10^n in 64 bits, evaluated at elaboration for the overflow threshold
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/binary_to_bcd_seq_if.sv
// ============================================================================
// Module      : binary_to_bcd_seq_if
// Description : Handshake and result bundle between a requester and the
//               sequential binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface binary_to_bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    import bcd_pkg::*;

    logic                          start;
    logic [BIN_W-1:0]              binary;
    logic                          ready;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
    logic                          overflow;
    logic [DIGITS-1:0]             blank;

    // Requester side: issues start/binary, observes the result
    modport master (
        output start, binary,
        input  ready, done, bcd, overflow, blank
    );

    // Converter side
    modport slave (
        input  start, binary,
        output ready, done, bcd, overflow, blank
    );

endinterface

`default_nettype wire

// File: rtl/binary_to_bcd_seq_digit_adj.sv
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble correction for one BCD digit: adds 3 when the
//               digit is 5 or more so the following left shift carries
//               correctly into the next decade.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
    import bcd_pkg::*;
(
    input  wire logic [BCD_DIGIT_W-1:0] i_digit,
    output logic      [BCD_DIGIT_W-1:0] o_digit
);

    // Legal digits 5..9 map to 8..12, so the result always fits in 4 bits
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
// ============================================================================
// Module      : binary_to_bcd_seq
// Description : Iterative double-dabble binary-to-BCD converter, one input
//               bit per clock, with start/ready/done handshake, saturating
//               overflow flag and leading-zero blank mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  wire logic           clk,
    input  wire logic           rst,
    binary_to_bcd_seq_if.slave  bus
);
    import bcd_pkg::*;

    localparam int c_scr_w = BCD_DIGIT_W * DIGITS;
    localparam int c_cnt_w = $clog2(BIN_W + 1);

    localparam logic [63:0]        c_max_dec   = pow10(DIGITS) - 64'd1;
    localparam logic [63:0]        c_max_bin   = (BIN_W >= 64) ? {64{1'b1}}
                                                 : ((64'd1 << BIN_W) - 64'd1);
    localparam logic [c_cnt_w-1:0] c_last_cnt  = c_cnt_w'(BIN_W - 1);
    localparam logic [c_scr_w-1:0] c_nines     = {DIGITS{4'd9}};
    localparam logic [DIGITS-1:0]  c_one       = DIGITS'(1);
    localparam logic [DIGITS-1:0]  c_blank_rst = ~c_one;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BIN_W-1:0]     r_bin;
    logic [c_scr_w-1:0]   r_scratch;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ovf_pend;
    logic [c_scr_w-1:0]   r_bcd;
    logic                 r_overflow;
    logic [DIGITS-1:0]    r_blank;
    logic                 r_done;

    logic [c_scr_w-1:0]   w_adj;
    logic                 w_ovf;
    logic [c_scr_w-1:0]   w_out_bcd;
    logic [DIGITS-1:0]    w_blank;
    logic                 w_zero_run;
    logic                 w_ready;
    // The top corrected bit falls off the end of the shift by design
    logic                 w_unused;

    assign w_unused = w_adj[c_scr_w-1];

    // Per-digit add-3 correction, all digits evaluated in parallel
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_adj u_adj (
            .i_digit (r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // When the digit range covers every input value, overflow cannot happen
    if (c_max_dec >= c_max_bin) begin : g_ovf_never
        assign w_ovf = 1'b0;
    end else begin : g_ovf_cmp
        assign w_ovf = (64'(bus.binary) > c_max_dec);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; ready only while idle
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == c_last_cnt) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Saturated result and leading-zero mask presented at the DONE edge
    always_comb begin
        w_out_bcd  = r_ovf_pend ? c_nines : r_scratch;
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_zero_run = w_zero_run & (w_out_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
            w_blank[i] = w_zero_run;
        end
        if (r_ovf_pend) begin
            w_blank = '0;
        end
    end

    // Operand capture, shift/correct iterations and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin      <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
            r_blank    <= c_blank_rst;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_bin      <= bus.binary;
                        r_scratch  <= '0;
                        r_ovf_pend <= w_ovf;
                        r_cnt      <= '0;
                    end
                end
                SHIFT: begin
                    r_scratch <= {w_adj[c_scr_w-2:0], r_bin[BIN_W-1]};
                    r_bin     <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt + c_cnt_w'(1);
                end
                DONE: begin
                    r_bcd      <= w_out_bcd;
                    r_overflow <= r_ovf_pend;
                    r_blank    <= w_blank;
                    r_done     <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready    = w_ready;
    assign bus.done     = r_done;
    assign bus.bcd      = r_bcd;
    assign bus.overflow = r_overflow;
    assign bus.blank    = r_blank;

endmodule

`default_nettype wire

// File: tb/tb_binary_to_bcd_seq.sv
// ============================================================================
// Module      : tb_binary_to_bcd_seq
// Description : Self-checking bench for binary_to_bcd_seq: directed vector
//               tables for a 5-digit and a 4-digit instance, hand-written
//               handshake/abort sequences and a strided value sweep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binary_to_bcd_seq;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
        logic [4:0]  blank;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    binary_to_bcd_seq_if #(.BIN_W(16), .DIGITS(5)) bus5 ();
    binary_to_bcd_seq_if #(.BIN_W(16), .DIGITS(4)) bus4 ();

    binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    binary_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Decimal digits of v by division, ones digit in the low nibble
    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input logic [19:0] d);
        logic [4:0] b;
        bit z;
        b = '0;
        z = 1'b1;
        for (int i = 4; i > 0; i--) begin
            z = z && (d[4*i +: 4] == 4'd0);
            b[i] = z;
        end
        return b;
    endfunction

    task automatic wait_done5(output int n);
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus5.done === 1'b1) got = 1'b1;
        end
        if (!got) n = -1;
    endtask

    // One conversion on the 5-digit instance; also reports whether the
    // outputs held and ready stayed low while shifting, and pulse width
    task automatic conv5(input logic [15:0] v, output int lat, output bit hold_ok,
                         output bit pulse_ok);
        logic [19:0] prev;
        bit got;
        @(negedge clk);
        bus5.start  = 1'b1;
        bus5.binary = v;
        prev = bus5.bcd;
        @(posedge clk); #1;
        bus5.start  = 1'b0;
        bus5.binary = ~v;
        lat = 0;
        got = 1'b0;
        hold_ok = 1'b1;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus5.done === 1'b1) begin
                got = 1'b1;
                if (bus5.ready !== 1'b1) hold_ok = 1'b0;
            end else if (bus5.bcd !== prev || bus5.ready !== 1'b0) begin
                hold_ok = 1'b0;
            end
        end
        if (!got) lat = -1;
        @(posedge clk); #1;
        pulse_ok = got && (bus5.done === 1'b0);
    endtask

    task automatic conv4(input logic [15:0] v, output int lat);
        bit got;
        @(negedge clk);
        bus4.start  = 1'b1;
        bus4.binary = v;
        @(posedge clk); #1;
        bus4.start  = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus4.done === 1'b1) got = 1'b1;
        end
        if (!got) lat = -1;
    endtask

    // Absolute bound on the run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab5[11];
        vec_t tab4[6];
        int   lat;
        int   n2;
        int   dones;
        int   rdy_bad;
        bit   hold_ok;
        bit   pulse_ok;
        logic [19:0] exp_bcd;
        logic [19:0] got_bcd;

        tab5[0]  = '{16'd0,     20'h00000, 5'b11110, 1'b0};
        tab5[1]  = '{16'd1234,  20'h01234, 5'b10000, 1'b0};
        tab5[2]  = '{16'd65535, 20'h65535, 5'b00000, 1'b0};
        tab5[3]  = '{16'd9,     20'h00009, 5'b11110, 1'b0};
        tab5[4]  = '{16'd10,    20'h00010, 5'b11100, 1'b0};
        tab5[5]  = '{16'd100,   20'h00100, 5'b11000, 1'b0};
        tab5[6]  = '{16'd1000,  20'h01000, 5'b10000, 1'b0};
        tab5[7]  = '{16'd10000, 20'h10000, 5'b00000, 1'b0};
        tab5[8]  = '{16'd42,    20'h00042, 5'b11100, 1'b0};
        tab5[9]  = '{16'd500,   20'h00500, 5'b11000, 1'b0};
        tab5[10] = '{16'd59999, 20'h59999, 5'b00000, 1'b0};

        tab4[0]  = '{16'd12345, 20'h09999, 5'b00000, 1'b1};
        tab4[1]  = '{16'd9999,  20'h09999, 5'b00000, 1'b0};
        tab4[2]  = '{16'd10000, 20'h09999, 5'b00000, 1'b1};
        tab4[3]  = '{16'd0,     20'h00000, 5'b01110, 1'b0};
        tab4[4]  = '{16'd123,   20'h00123, 5'b01000, 1'b0};
        tab4[5]  = '{16'd65535, 20'h09999, 5'b00000, 1'b1};

        bus5.start = 1'b0;  bus5.binary = '0;
        bus4.start = 1'b0;  bus4.binary = '0;

        // Reset state
        rst = 1'b1;
        #12;
        check("rst.ready",    32'(bus5.ready),    32'd1);
        check("rst.done",     32'(bus5.done),     32'd0);
        check("rst.bcd",      32'(bus5.bcd),      32'h0);
        check("rst.overflow", 32'(bus5.overflow), 32'd0);
        check("rst.blank",    32'(bus5.blank),    32'b11110);
        check("rst4.blank",   32'(bus4.blank),    32'b1110);
        @(negedge clk);
        rst = 1'b0;

        // Directed table, 5-digit instance
        foreach (tab5[i]) begin
            conv5(tab5[i].bin, lat, hold_ok, pulse_ok);
            check($sformatf("t5[%0d].latency", i), 32'(lat), 32'd17);
            check($sformatf("t5[%0d].bcd", i),     32'(bus5.bcd),      32'(tab5[i].bcd));
            check($sformatf("t5[%0d].blank", i),   32'(bus5.blank),    32'(tab5[i].blank));
            check($sformatf("t5[%0d].ovf", i),     32'(bus5.overflow), 32'(tab5[i].ovf));
            check($sformatf("t5[%0d].hold", i),    32'(hold_ok),       32'd1);
            check($sformatf("t5[%0d].pulse", i),   32'(pulse_ok),      32'd1);
        end

        // Back-to-back with start held: second accept one cycle after done
        @(negedge clk);
        bus5.start  = 1'b1;
        bus5.binary = 16'd1234;
        @(posedge clk); #1;
        wait_done5(lat);
        check("b2b.first_latency", 32'(lat),       32'd17);
        check("b2b.first_bcd",     32'(bus5.bcd),  32'h01234);
        bus5.binary = 16'd65535;
        wait_done5(n2);
        bus5.start = 1'b0;
        check("b2b.period",        32'(n2),        32'd18);
        check("b2b.second_bcd",    32'(bus5.bcd),  32'h65535);
        check("b2b.second_blank",  32'(bus5.blank), 32'b00000);

        // Directed table, 4-digit instance with saturation
        foreach (tab4[i]) begin
            conv4(tab4[i].bin, lat);
            check($sformatf("t4[%0d].latency", i), 32'(lat), 32'd17);
            check($sformatf("t4[%0d].bcd", i),     32'(bus4.bcd),      32'(tab4[i].bcd));
            check($sformatf("t4[%0d].blank", i),   32'(bus4.blank),    32'(tab4[i].blank));
            check($sformatf("t4[%0d].ovf", i),     32'(bus4.overflow), 32'(tab4[i].ovf));
        end

        // Start pulses while busy are ignored, binary changes too
        @(negedge clk);
        bus5.start  = 1'b1;
        bus5.binary = 16'd42;
        @(posedge clk); #1;
        bus5.start = 1'b0;
        dones   = 0;
        rdy_bad = 0;
        got_bcd = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 3 || c == 5 || c == 10) begin
                bus5.start  = 1'b1;
                bus5.binary = 16'd999;
            end else begin
                bus5.start = 1'b0;
            end
            @(posedge clk); #1;
            if (c < 17 && bus5.ready !== 1'b0) rdy_bad++;
            if (bus5.done === 1'b1) begin
                dones++;
                got_bcd = bus5.bcd;
            end
        end
        bus5.start = 1'b0;
        check("busy.done_count", 32'(dones),   32'd1);
        check("busy.bcd",        32'(got_bcd), 32'h00042);
        check("busy.ready_low",  32'(rdy_bad), 32'd0);

        // Asynchronous abort mid-conversion
        @(negedge clk);
        bus5.start  = 1'b1;
        bus5.binary = 16'd500;
        @(posedge clk); #1;
        bus5.start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort.ready",    32'(bus5.ready),    32'd1);
        check("abort.done",     32'(bus5.done),     32'd0);
        check("abort.bcd",      32'(bus5.bcd),      32'h0);
        check("abort.overflow", 32'(bus5.overflow), 32'd0);
        check("abort.blank",    32'(bus5.blank),    32'b11110);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus5.done === 1'b1) dones++;
        end
        check("abort.no_done",  32'(dones),    32'd0);
        conv5(16'd500, lat, hold_ok, pulse_ok);
        check("abort.redo_lat", 32'(lat),      32'd17);
        check("abort.redo_bcd", 32'(bus5.bcd), 32'h00500);

        // Strided sweep against the division model
        for (int v = 0; v < 65536; v += 37) begin
            conv5(16'(v), lat, hold_ok, pulse_ok);
            exp_bcd = ref_bcd(v);
            check($sformatf("sweep[%0d].bcd", v),   32'(bus5.bcd),      32'(exp_bcd));
            check($sformatf("sweep[%0d].blank", v), 32'(bus5.blank),    32'(ref_blank(exp_bcd)));
            check($sformatf("sweep[%0d].ovf", v),   32'(bus5.overflow), 32'd0);
            check($sformatf("sweep[%0d].pulse", v), 32'(pulse_ok),      32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/binary_to_bcd_seq.md
Name: binary_to_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using iterative double-dabble, one bit per clock. It is the clocked successor to the combinational 16-bit/4-digit converter. It adds:
- configurable input width and digit count
- a start/ready/done handshake
- a saturating overflow flag
- a leading-zero blank mask for the display path.

It sits between the lifetime/count registers and the 7-segment display driver, so the display path no longer needs a deep combinational chain.

Parameters:
- BIN_W, 16: binary input width in bits (≥ 4).
- DIGITS, 5: number of BCD output digits (≥ 1). Maximum representable value is 10^DIGITS − 1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a conversion; accepted only when ready=1
- binary  input  BIN_W  value to convert; sampled on the accepting edge only
- ready  output  1  converter idle; able to accept start
- done  output  1  one-cycle pulse; bcd/overflow/blank valid and updated
- bcd  output  4*DIGITS  packed digits, digit 0 (ones) in bits [3:0]
- overflow  output  1  input exceeded 10^DIGITS − 1; bcd saturated
- blank  output  DIGITS  per-digit leading-zero blank mask for the display

Behaviour:
- One clock domain. rst is asynchronous and active-high and is the only reset.
- Reset values: state=IDLE, ready=1, done=0, bcd=0, overflow=0, blank={DIGITS-1{1}, 0}. Internal shift/scratch registers and the counter are 0.
- FSM states: IDLE, SHIFT, DONE. ready=1 only in IDLE.
- IDLE:
  - On start=1, latch binary and clear the BCD scratch (4*DIGITS bits).
  - Compute ovf_pend = (binary > 10^DIGITS − 1). If 10^DIGITS − 1 ≥ 2^BIN_W − 1, ovf_pend is constant 0.
  - Set cnt=0 and go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, one bit per cycle:
  - Add-3 correction: each scratch digit ≥ 5 gets +3, all digits in parallel.
  - Shift {scratch, bin} left by 1. The top scratch bit is discarded.
  - cnt++. After the BIN_W-th shift, go to DONE.
  - cnt width is $clog2(BIN_W+1).
- DONE, one cycle:
  - Register outputs. bcd = ovf_pend ? all digits 9 : scratch. overflow = ovf_pend.
  - blank[i] = 1 iff i > 0 and output digits i..DIGITS−1 are all zero. Digit 0 is never blanked. On overflow, blank = 0.
  - done=1 for exactly this cycle, then go to IDLE.
- Latency: start accepted at edge k → done high in the cycle following edge k+BIN_W+1. Outputs are valid from that edge.
- Minimum start-to-start period is BIN_W+2 cycles.
- bcd/overflow/blank hold their values until the next DONE; they do not change during SHIFT.
- start while ready=0 (SHIFT/DONE) is ignored, not queued. Changes on binary after acceptance have no effect.
- rst asserted mid-conversion aborts immediately to the reset values. No done pulse is issued for the aborted conversion.
- Widths are fixed by parameters. No internal value may exceed 4 bits per digit after correction.
- The 10^DIGITS constant is computed at elaboration with sufficient width (64-bit).

Decomposition:
- Package bcd_pkg:
  - BCD_DIGIT_W = 4
  - state enum {IDLE, SHIFT, DONE}
  - constant function pow10(n) returning 64-bit 10^n, used for the overflow threshold.
- One sub-module, bcd_digit_adj: 4-bit in → 4-bit out, +3 if ≥ 5. It is instantiated DIGITS times in a generate loop.
- The blank-mask logic stays inline.

Test Plan:
1. Default params, start with binary=0 → done 17 cycles after the accept edge; bcd=0x00000, overflow=0, blank=5'b11110.
2. binary=1234 → bcd=0x01234, blank=5'b10000, overflow=0. Then binary=65535 → bcd=0x65535, blank=5'b00000. Check the 18-cycle start-to-start period.
3. Instance BIN_W=16, DIGITS=4, binary=12345 → overflow=1, bcd=0x9999, blank=0. Then binary=9999 → overflow=0, bcd=0x9999.
4. Pulse start with binary=42 at cycles 3, 5 and 10 after accept → only the first conversion occurs; bcd=0x00042 once; ready=0 throughout; exactly one done pulse.
5. Assert rst 8 cycles into a conversion of 500 → outputs return to reset values within the cycle. No done pulse. A fresh start with 500 afterwards gives bcd=0x00500.
6. Sweep 0..65535 with default params against a reference model → every bcd matches decimal digits; done is a single-cycle pulse each time.
